// File: rtl/ascii_cell_tiler_if.sv
// ascii_cell_tiler_if: video-in / text-out signal bundle for ascii_cell_tiler.
// The master side is the pixel source plus text consumer; the slave side is the tiler.
interface ascii_cell_tiler_if;
    logic        frame_start;
    logic        DE;
    logic [23:0] rgb_in;
    logic        invert;
    logic [7:0]  ascii_char;
    logic        ascii_valid;
    logic        ascii_ready;
    logic        frame_done;
    logic        overflow;
    modport master (
        output frame_start, DE, rgb_in, invert, ascii_ready,
        input  ascii_char, ascii_valid, frame_done, overflow
    );
    modport slave (
        input  frame_start, DE, rgb_in, invert, ascii_ready,
        output ascii_char, ascii_valid, frame_done, overflow
    );
endinterface

// File: rtl/ascii_cell_tiler.sv
// ascii_cell_tiler: averages CELL_W x CELL_H luminance cells into ASCII characters plus
// end-of-row newlines, queued in a first-word-fall-through output FIFO.
module ascii_cell_tiler #(
    parameter int H_ACT      = 640,
    parameter int V_ACT      = 480,
    parameter int CELL_W     = 8,
    parameter int CELL_H     = 16,
    parameter int FIFO_DEPTH = H_ACT / CELL_W + 2
) (
    input logic clk,
    input logic reset_n,
    ascii_cell_tiler_if.slave bus
);
    localparam int COLS = H_ACT / CELL_W;
    localparam int ROWS = V_ACT / CELL_H;
    localparam int LW   = $clog2(CELL_W);
    localparam int LH   = $clog2(CELL_H);
    localparam int AW   = 8 + LW + LH;
    localparam int XW   = $clog2(H_ACT + 1);
    localparam int YW   = $clog2(V_ACT + 1);
    localparam int CI   = COLS > 1 ? $clog2(COLS) : 1;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam logic [7:0] RAMP [10] = '{8'h20, 8'h2E, 8'h3A, 8'h2D, 8'h3D,
                                         8'h2B, 8'h2A, 8'h23, 8'h25, 8'h40};

    logic          s1_v_q, inv_q, nl_q, nl_last_q, frame_done_q, ovf_q;
    logic [7:0]    gray_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [AW-1:0] acc_q [2**CI];
    logic [7:0]    mem_q [2**PW];
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q;

    logic [15:0]   lum;
    logic [XW-1:0] px, col;
    logic [YW-1:0] cy, row;
    logic [CI-1:0] ci;
    logic [AW-1:0] sum;
    logic [7:0]    avg, push_data;
    logic [3:0]    lvl, idx;
    logic          s1_go, nl_go, cell_push, push, pop, wr_ok;

    always_comb begin
        lum       = 16'd77 * {8'd0, bus.rgb_in[23:16]} + 16'd150 * {8'd0, bus.rgb_in[15:8]}
                  + 16'd29 * {8'd0, bus.rgb_in[7:0]};
        px        = x_q & XW'(CELL_W - 1);
        col       = x_q >> LW;
        cy        = y_q & YW'(CELL_H - 1);
        row       = y_q >> LH;
        ci        = CI'(col);
        sum       = acc_q[ci] + AW'(gray_q);
        avg       = 8'(sum >> (LW + LH));
        lvl       = 4'(({4'd0, avg} * 12'd10) >> 8);
        idx       = inv_q ? 4'd9 - lvl : lvl;
        // frame_start discards whatever is in flight, including a pending newline
        s1_go     = s1_v_q && !bus.frame_start;
        nl_go     = nl_q && !bus.frame_start;
        cell_push = s1_go && px == XW'(CELL_W - 1) && cy == YW'(CELL_H - 1);
        push      = nl_go || cell_push;
        push_data = nl_go ? 8'h0A : RAMP[idx];
        pop       = cnt_q != '0 && bus.ascii_ready;
        wr_ok     = push && (cnt_q != CW'(FIFO_DEPTH) || pop);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_v_q       <= 1'b0;
            gray_q       <= '0;
            inv_q        <= 1'b0;
            nl_q         <= 1'b0;
            nl_last_q    <= 1'b0;
            frame_done_q <= 1'b0;
            ovf_q        <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            rd_q         <= '0;
            wr_q         <= '0;
            cnt_q        <= '0;
            for (int i = 0; i < 2**CI; i++) acc_q[i] <= '0;
        end else begin
            s1_v_q       <= bus.DE;
            gray_q       <= 8'(lum >> 8);
            inv_q        <= bus.invert;
            nl_q         <= cell_push && col == XW'(COLS - 1);
            frame_done_q <= nl_go && nl_last_q;
            ovf_q        <= !bus.frame_start && (ovf_q || (push && !wr_ok));
            if (cell_push) nl_last_q <= row == YW'(ROWS - 1);
            if (bus.frame_start) begin
                x_q <= '0;
                y_q <= '0;
            end else if (s1_go) begin
                x_q <= x_q == XW'(H_ACT - 1) ? '0 : x_q + 1'b1;
                if (x_q == XW'(H_ACT - 1)) y_q <= y_q == YW'(V_ACT - 1) ? '0 : y_q + 1'b1;
            end
            if (s1_go) acc_q[ci] <= (px == '0 && cy == '0) ? AW'(gray_q) : sum;
            if (wr_ok) wr_q <= wr_q == PW'(FIFO_DEPTH - 1) ? '0 : wr_q + 1'b1;
            if (pop) rd_q <= rd_q == PW'(FIFO_DEPTH - 1) ? '0 : rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(wr_ok) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_q] <= push_data;
    end

    assign bus.ascii_char  = cnt_q != '0 ? mem_q[rd_q] : 8'h00;
    assign bus.ascii_valid = cnt_q != '0;
    assign bus.frame_done  = frame_done_q;
    assign bus.overflow    = ovf_q;

    // A newline and a character can never share a push slot when lines have a DE gap
    assert property (@(posedge clk) disable iff (!reset_n) !(nl_go && cell_push));
endmodule

// File: tb/tb_ascii_cell_tiler.sv
// tb_ascii_cell_tiler: directed frames on a 16x8 / 4x4-cell tiler with a queue scoreboard
// checked by an independent output monitor.
module tb_ascii_cell_tiler;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int cyc = 0, n_cmp = 0, n_bad = 0;
    int pops = 0, fd_cnt = 0, fd_pos = -1, first_rise = -1, t_last = 0;
    int fd_char = 0;
    logic [7:0] exp_q [$];

    ascii_cell_tiler_if bus ();
    ascii_cell_tiler #(.H_ACT(16), .V_ACT(8), .CELL_W(4), .CELL_H(4), .FIFO_DEPTH(6)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_str(input string s);
        foreach (s[i]) exp_q.push_back(s[i]);
    endtask

    // mode 0 white, 1 black, 2 per-column: gray128 | half white/black | white | black
    function automatic logic [23:0] pix(input int mode, input int x);
        if (mode == 0) return 24'hFFFFFF;
        if (mode == 1) return 24'h000000;
        if (x < 4) return 24'h808080;
        if (x < 8) return (x % 4 < 2) ? 24'hFFFFFF : 24'h000000;
        return (x < 12) ? 24'hFFFFFF : 24'h000000;
    endfunction

    task automatic send_frame(input int mode, input logic inv);
        bus.invert = inv;
        bus.frame_start = 1'b1;
        bus.DE = 1'b0;
        tick;
        bus.frame_start = 1'b0;
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 16; x++) begin
                bus.DE = 1'b1;
                bus.rgb_in = pix(mode, x);
                if (x == 3 && y == 3) t_last = cyc;
                tick;
            end
            bus.DE = 1'b0;
            tick;
            tick;
        end
        repeat (4) tick;
    endtask

    task automatic drain;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick;
        tick;
        chk("drained", exp_q.size(), 0);
        chk("valid_after_drain", bus.ascii_valid, 0);
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (first_rise < 0 && bus.ascii_valid) first_rise = cyc;
            if (bus.frame_done) begin
                fd_cnt++;
                fd_pos = pops;
                fd_char = bus.ascii_char;
            end
            if (bus.ascii_valid && bus.ascii_ready) begin
                if (exp_q.size() == 0) chk("unexpected_entry", bus.ascii_char, -1);
                else chk("char", bus.ascii_char, exp_q.pop_front());
                pops++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.frame_start = 1'b0;
        bus.DE = 1'b0;
        bus.rgb_in = '0;
        bus.invert = 1'b0;
        bus.ascii_ready = 1'b1;
        repeat (2) tick;
        chk("rst_char", bus.ascii_char, 0);
        chk("rst_valid", bus.ascii_valid, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        chk("rst_overflow", bus.overflow, 0);
        reset_n = 1'b1;
        tick;

        first_rise = -1; pops = 0; fd_cnt = 0;
        expect_str("@@@@\n@@@@\n");
        send_frame(0, 1'b0);
        chk("latency", first_rise - t_last, 2);
        chk("frame_done_count", fd_cnt, 1);
        chk("frame_done_pos", fd_pos, 9);
        chk("frame_done_char", fd_char, 8'h0A);

        expect_str("@@@@\n@@@@\n");
        send_frame(1, 1'b1);
        expect_str("    \n    \n");
        send_frame(1, 1'b0);
        expect_str("+=@ \n+=@ \n");
        send_frame(2, 1'b0);
        chk("empty_after_mixed", exp_q.size(), 0);

        bus.ascii_ready = 1'b0;
        expect_str("@@@@\n@");
        send_frame(0, 1'b0);
        chk("bp_overflow", bus.overflow, 1);
        chk("bp_valid", bus.ascii_valid, 1);
        chk("bp_head", bus.ascii_char, 8'h40);
        bus.ascii_ready = 1'b1;
        drain;
        chk("overflow_sticky", bus.overflow, 1);

        bus.ascii_ready = 1'b0;
        expect_str("@@@@\n@");
        send_frame(0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (i == 16) begin
                bus.DE = 1'b0;
                tick;
                tick;
            end
            bus.DE = 1'b1;
            bus.rgb_in = 24'hFFFFFF;
            tick;
        end
        bus.DE = 1'b0;
        reset_n = 1'b0;
        tick;
        reset_n = 1'b1;
        exp_q.delete();
        chk("mid_rst_char", bus.ascii_char, 0);
        chk("mid_rst_valid", bus.ascii_valid, 0);
        chk("mid_rst_frame_done", bus.frame_done, 0);
        chk("mid_rst_overflow", bus.overflow, 0);
        bus.ascii_ready = 1'b1;
        pops = 0; fd_cnt = 0;
        expect_str("@@@@\n@@@@\n");
        send_frame(0, 1'b0);
        chk("rerun_frame_done_count", fd_cnt, 1);
        chk("rerun_frame_done_pos", fd_pos, 9);
        drain;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ascii_cell_tiler.md
# ascii_cell_tiler

Parametrised successor to the per-pixel ASCII path. The block converts the active RGB video stream into one ASCII character per CELL_W×CELL_H pixel cell. It averages cell luminance and maps it through a 10-level ramp, with optional inversion. Characters and newlines go into an output FIFO with a valid/ready handshake. It sits after the BMP/VGA pixel source and feeds the UART/text sink.

## Interface
- H_ACT, 640, active pixels per line; must be a multiple of CELL_W.
- V_ACT, 480, active lines per frame; must be a multiple of CELL_H.
- CELL_W, 8, cell width in pixels; power of two, 1..16.
- CELL_H, 16, cell height in lines; power of two, 1..16.
- COLS = H_ACT/CELL_W and ROWS = V_ACT/CELL_H are derived, not overridable.
- FIFO_DEPTH, COLS+2, output FIFO entries; must be ≥ COLS+1.

Ports:
- clk, in, 1: sole clock.
- reset_n, in, 1: synchronous reset, active-low.
- frame_start, in, 1: one-cycle pulse; restarts pixel/line counters and discards partial accumulations.
- DE, in, 1: pixel valid; one pixel per cycle while high.
- rgb_in, in, 24: {R[23:16], G[15:8], B[7:0]}.
- invert, in, 1: sampled at the cell's final pixel; 1 = reversed ramp.
- ascii_char, out, 8: FIFO head (first-word fall-through); 0x00 when empty.
- ascii_valid, out, 1: FIFO non-empty.
- ascii_ready, in, 1: consumer accept; a pop occurs when ascii_valid && ascii_ready.
- frame_done, out, 1: one-cycle pulse when the last newline of the frame is pushed.
- overflow, out, 1: sticky; set when a push hits a full FIFO; cleared only by reset or frame_start.

## Operation
- **Stage 1 (registered):** gray = (77·R + 150·G + 29·B) >> 8, 8 bits. White gives 255; black gives 0.
- **Counters:** x advances on every DE cycle and wraps H_ACT-1→0. y increments on the x wrap and wraps V_ACT-1→0. Indices are derived as col = x/CELL_W, px = x%CELL_W, cy = y%CELL_H, row = y/CELL_H. All counters advance from stage-1 valid.
- **Accumulator array:** COLS entries, each 8+log2(CELL_W·CELL_H) bits wide.
  - When px==0 && cy==0, the entry loads gray.
  - Otherwise the entry adds gray.
- **Cell completion:** occurs on px==CELL_W-1 && cy==CELL_H-1.
  - avg = (acc+gray) >> log2(CELL_W·CELL_H).
  - idx = (avg·10) >> 8, range 0..9.
  - If invert, idx = 9-idx.
  - The character is ramp[idx]: 0x20 ' ', 0x2E '.', 0x3A ':', 0x2D '-', 0x3D '=', 0x2B '+', 0x2A '*', 0x23 '#', 0x25 '%', 0x40 '@'.
- **Newline:** after the col==COLS-1 character, 0x0A is pushed on the next cycle. At most one push per cycle.
  - The line wrap gap is ≥1 cycle, and the source guarantees DE low for ≥1 cycle between lines.
  - If DE stays high, the newline has priority and the character collides. Behaviour in that case is undefined and is asserted against in simulation.
- **frame_done:** pulses with the newline push when row==ROWS-1.
- **FIFO full on push:** the entry is dropped and overflow is set. The FIFO contents and the pop side are unaffected. Simultaneous push and pop at full with ascii_ready=1 succeeds (pop first).
- **frame_start:**
  - Clears x, y, the stage-1 valid, any pending newline, and overflow.
  - Does not flush the FIFO.
  - A frame_start coincident with DE treats that pixel as x=0, y=0.
- **Reset:** clears all state including the FIFO. A reset mid-frame means output resumes only after the next frame_start or after the counters naturally align. Counters restart at 0 on reset.

## Timing
- **Latency:** the cell's final pixel is accepted in cycle N, gray is registered at N+1, and the character is pushed (visible at ascii_char/ascii_valid) at N+2. The newline is visible no earlier than N+3.
- **Reset values:** ascii_char 0x00, ascii_valid 0, frame_done 0, overflow 0.
- **Hold rule:** ascii_char is stable while ascii_valid && !ascii_ready. The next entry appears the cycle after a pop.
- **Throughput:** sustained drain of 1 entry/cycle.

## Test plan
- **All-white frame** (H_ACT=16, V_ACT=8, CELL 4×4, ascii_ready=1): stream is "@@@@\n@@@@\n"; one frame_done, co-cycle with the second 0x0A.
- **All-black frame with invert=1:** every character is '@'. With invert=0 every character is ' ' (0x20).
- **Mid-gray, mixed cell:** a cell with rgb=0x808080 (gray 128) gives idx 5, '+'. A cell where half the pixels are 255 and half are 0 gives avg 127, idx 4, '='.
- **Backpressure:** hold ascii_ready=0 for a whole frame with FIFO_DEPTH=6.
  - First 6 entries "@@@@\n@" are retained and overflow=1.
  - On release they drain in order.
- **Latency check:** ascii_valid rises exactly 2 cycles after the first cell's last pixel.
- **Reset mid-frame:** apply reset_n=0 for 1 cycle after 20 pixels. All outputs go to their reset values; after frame_start, a full frame reproduces the first test's output exactly.
